// File: rtl/multi_alarm_ctrl.sv
// Alarm clock controller: BCD time of day, N editable alarms, and a ring
// sequencer with snooze and auto-stop.
//
// Edit FSM   | meaning
// E_RUN      | clock runs, edit keys ignored
// E_HOUR     | add/sub change the hour of the selected target
// E_MIN      | add/sub change the minute of the selected target
//
// Ring FSM   | meaning
// QUIET      | no alarm active
// RINGING    | ring asserted for alarm ring_id
// SNOOZED    | waiting SNOOZE_MIN minute boundaries before ringing again
module multi_alarm_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int N_ALARM    = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 1,
    localparam int IW        = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sel_alarm,
    input  logic [IW-1:0]   alarm_idx,
    input  logic [N_ALARM-1:0] alarm_en,
    input  logic            key_adj,
    input  logic            key_add,
    input  logic            key_sub,
    input  logic            snooze,
    input  logic            stop,
    output logic [3:0]      hour_h,
    output logic [3:0]      hour_l,
    output logic [3:0]      min_h,
    output logic [3:0]      min_l,
    output logic [3:0]      sec_h,
    output logic [3:0]      sec_l,
    output logic [3:0]      al_hour_h,
    output logic [3:0]      al_hour_l,
    output logic [3:0]      al_min_h,
    output logic [3:0]      al_min_l,
    output logic [1:0]      adjust,
    output logic            ring,
    output logic [IW-1:0]   ring_id,
    output logic            sec_tick
);
    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

    typedef enum logic [1:0] {E_RUN = 2'd0, E_HOUR = 2'd1, E_MIN = 2'd2} edit_t;
    typedef enum logic [1:0] {QUIET = 2'd0, RINGING = 2'd1, SNOOZED = 2'd2} ring_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)          return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                   return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)        return max;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                   return {v[7:4], v[3:0] - 4'd1};
    endfunction

    logic [PW-1:0] presc, presc_n;
    logic [7:0]    hh, mm, ss, hh_n, mm_n, ss_n;
    logic [7:0]    al_hh [N_ALARM];
    logic [7:0]    al_mm [N_ALARM];
    edit_t         edit_st, edit_nx;
    ring_t         ring_st, ring_nx;
    logic [5:0]    rcnt, rcnt_n;
    logic [IW-1:0] rid, rid_n, hit_id;
    logic          hit, match, min_tick, armed, key_ok, edit_time, idx_ok;

    assign sec_tick  = (presc == PRESC_MAX);
    assign key_ok    = (key_add ^ key_sub) && (edit_st != E_RUN);
    assign edit_time = !sel_alarm && (edit_st != E_RUN);
    assign idx_ok    = int'(alarm_idx) < N_ALARM;
    assign min_tick  = sec_tick && (ss == 8'h59);
    assign armed     = alarm_en[rid];

    always_comb begin
        edit_nx = edit_st;
        if (key_adj) begin
            case (edit_st)
                E_RUN:   edit_nx = E_HOUR;
                E_HOUR:  edit_nx = E_MIN;
                default: edit_nx = E_RUN;
            endcase
        end
    end

    // Seconds keep counting while the time is being edited, but never carry.
    always_comb begin
        presc_n = sec_tick ? '0 : presc + PW'(1);
        hh_n = hh;
        mm_n = mm;
        ss_n = ss;
        if (sec_tick) begin
            ss_n = bcd_inc(ss, 8'h59);
            if (ss == 8'h59 && !edit_time) begin
                mm_n = bcd_inc(mm, 8'h59);
                if (mm == 8'h59) hh_n = bcd_inc(hh, 8'h23);
            end
        end
        if (key_ok && !sel_alarm) begin
            if (edit_st == E_HOUR) begin
                hh_n = key_add ? bcd_inc(hh, 8'h23) : bcd_dec(hh, 8'h23);
            end else if (edit_st == E_MIN) begin
                mm_n    = key_add ? bcd_inc(mm, 8'h59) : bcd_dec(mm, 8'h59);
                ss_n    = 8'h00;
                presc_n = '0;
            end
        end
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (alarm_en[i] && al_hh[i] == hh_n && al_mm[i] == mm_n) begin
                hit    = 1'b1;
                hit_id = IW'(i);
            end
        end
    end

    assign match = sec_tick && (ss_n == 8'h00) && hit;

    always_comb begin
        ring_nx = ring_st;
        rcnt_n  = rcnt;
        rid_n   = rid;
        case (ring_st)
            QUIET: begin
                if (match) begin
                    ring_nx = RINGING;
                    rcnt_n  = 6'(RING_MIN);
                    rid_n   = hit_id;
                end
            end
            RINGING: begin
                if (stop || !armed) begin
                    ring_nx = QUIET;
                end else if (snooze) begin
                    ring_nx = SNOOZED;
                    rcnt_n  = 6'(SNOOZE_MIN);
                end else if (min_tick) begin
                    if (rcnt == 6'd1) ring_nx = QUIET;
                    else              rcnt_n  = rcnt - 6'd1;
                end
            end
            SNOOZED: begin
                if (stop || !armed) begin
                    ring_nx = QUIET;
                end else if (min_tick) begin
                    if (rcnt == 6'd1) begin
                        ring_nx = RINGING;
                        rcnt_n  = 6'(RING_MIN);
                    end else begin
                        rcnt_n = rcnt - 6'd1;
                    end
                end
            end
            default: ring_nx = QUIET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            hh      <= 8'h00;
            mm      <= 8'h00;
            ss      <= 8'h00;
            edit_st <= E_RUN;
            ring_st <= QUIET;
            rcnt    <= '0;
            rid     <= '0;
            for (int i = 0; i < N_ALARM; i++) begin
                al_hh[i] <= 8'h00;
                al_mm[i] <= 8'h00;
            end
        end else begin
            presc   <= presc_n;
            hh      <= hh_n;
            mm      <= mm_n;
            ss      <= ss_n;
            edit_st <= edit_nx;
            ring_st <= ring_nx;
            rcnt    <= rcnt_n;
            rid     <= rid_n;
            if (key_ok && sel_alarm && idx_ok) begin
                if (edit_st == E_HOUR)
                    al_hh[alarm_idx] <= key_add ? bcd_inc(al_hh[alarm_idx], 8'h23)
                                                : bcd_dec(al_hh[alarm_idx], 8'h23);
                else if (edit_st == E_MIN)
                    al_mm[alarm_idx] <= key_add ? bcd_inc(al_mm[alarm_idx], 8'h59)
                                                : bcd_dec(al_mm[alarm_idx], 8'h59);
            end
        end
    end

    always_comb begin
        {al_hour_h, al_hour_l, al_min_h, al_min_l} = 16'h0000;
        if (idx_ok) {al_hour_h, al_hour_l, al_min_h, al_min_l} = {al_hh[alarm_idx], al_mm[alarm_idx]};
    end

    assign {hour_h, hour_l} = hh;
    assign {min_h, min_l}   = mm;
    assign {sec_h, sec_l}   = ss;
    assign adjust           = edit_st;
    assign ring             = (ring_st == RINGING);
    assign ring_id          = rid;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl with a 10-cycle second, four alarms,
// five-minute snooze and one-minute auto-stop.
module tb_multi_alarm_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_alarm = 1'b0;
    logic [1:0] alarm_idx = 2'd0;
    logic [3:0] alarm_en = 4'b0000;
    logic       key_adj = 1'b0, key_add = 1'b0, key_sub = 1'b0, snooze = 1'b0, stop = 1'b0;
    logic [3:0] hour_h, hour_l, min_h, min_l, sec_h, sec_l;
    logic [3:0] al_hour_h, al_hour_l, al_min_h, al_min_l;
    logic [1:0] adjust;
    logic       ring, sec_tick;
    logic [1:0] ring_id;

    int checks = 0;
    int errors = 0;

    multi_alarm_ctrl #(.CLK_FREQ(10), .N_ALARM(4), .SNOOZE_MIN(5), .RING_MIN(1)) dut (
        .clk(clk), .rst(rst), .sel_alarm(sel_alarm), .alarm_idx(alarm_idx),
        .alarm_en(alarm_en), .key_adj(key_adj), .key_add(key_add), .key_sub(key_sub),
        .snooze(snooze), .stop(stop),
        .hour_h(hour_h), .hour_l(hour_l), .min_h(min_h), .min_l(min_l),
        .sec_h(sec_h), .sec_l(sec_l),
        .al_hour_h(al_hour_h), .al_hour_l(al_hour_l), .al_min_h(al_min_h), .al_min_l(al_min_l),
        .adjust(adjust), .ring(ring), .ring_id(ring_id), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] now_t();
        return 32'({hour_h, hour_l, min_h, min_l, sec_h, sec_l});
    endfunction

    function automatic logic [31:0] al_t();
        return 32'({al_hour_h, al_hour_l, al_min_h, al_min_l});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_adj();
        key_adj = 1'b1; step(1); key_adj = 1'b0;
    endtask

    task automatic press_add();
        key_add = 1'b1; step(1); key_add = 1'b0;
    endtask

    task automatic press_sub();
        key_sub = 1'b1; step(1); key_sub = 1'b0;
    endtask

    // Advance n seconds: wait for each tick, then let its edge update the time.
    task automatic adv(input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            c = 0;
            while (sec_tick !== 1'b1 && c < 20) begin
                step(1);
                c++;
            end
            if (c >= 20) begin
                check("tick_timeout", 32'(sec_tick), 1);
                return;
            end
            step(1);
        end
    endtask

    // Set the clock to 07:29 (seconds cleared) and return to RUN.
    task automatic goto_0729();
        int c;
        sel_alarm = 1'b0;
        press_adj();
        c = 0;
        while ({hour_h, hour_l} != 8'h07 && c < 30) begin press_add(); c++; end
        press_adj();
        c = 0;
        while ({min_h, min_l} != 8'h29 && c < 70) begin press_add(); c++; end
        press_adj();
    endtask

    task automatic run_to_alarm(input string tag);
        int c, early;
        c = 0;
        early = 0;
        while (now_t() != 32'h073000 && c < 120) begin
            if (ring) early++;
            adv(1);
            c++;
        end
        check({tag, "_time"}, now_t(), 'h073000);
        check({tag, "_early"}, 32'(early), 0);
    endtask

    initial begin
        int c, bad, glitch;

        // reset values
        step(3);
        check("rst_time", now_t(), 'h000000);
        check("rst_adjust", 32'(adjust), 0);
        check("rst_ring", 32'(ring), 0);
        check("rst_ring_id", 32'(ring_id), 0);
        check("rst_sec_tick", 32'(sec_tick), 0);
        check("rst_alarm0", al_t(), 'h0000);
        rst = 1'b0;

        // sec_tick spacing from reset release, 100 seconds
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            c = 0;
            while (sec_tick !== 1'b1 && c < 20) begin step(1); c++; end
            if (c != 9) bad++;
            if (c >= 20) break;
            step(1);
        end
        check("tick_spacing", 32'(bad), 0);
        check("time_100s", now_t(), 'h000140);

        // time edit: hour 00->23, minute 01->00->59
        press_adj();
        check("adj_hour", 32'(adjust), 1);
        press_sub();
        check("hour_dec_wrap", now_t(), 'h230140);
        key_add = 1'b1; key_sub = 1'b1; step(1); key_add = 1'b0; key_sub = 1'b0;
        check("add_sub_ignored", now_t(), 'h230140);
        press_adj();
        check("adj_min", 32'(adjust), 2);
        press_sub();
        check("min_dec_clr_sec", now_t(), 'h230000);
        press_sub();
        check("min_dec_wrap", now_t(), 'h235900);
        adv(60);
        check("carry_suppressed", now_t(), 'h235900);
        press_adj();
        check("adj_run", 32'(adjust), 0);
        adv(60);
        check("midnight_wrap", now_t(), 'h000000);
        press_add();
        check("run_keys_ignored", now_t(), 'h000000);

        // alarms 1 and 2 to 07:30
        sel_alarm = 1'b1;
        alarm_idx = 2'd1;
        press_adj();
        repeat (7) press_add();
        press_adj();
        repeat (30) press_sub();
        check("alarm1_set", al_t(), 'h0730);
        press_adj();
        alarm_idx = 2'd2;
        press_adj();
        repeat (17) press_sub();
        press_adj();
        repeat (30) press_add();
        check("alarm2_set", al_t(), 'h0730);
        press_adj();
        alarm_idx = 2'd0;
        step(1);
        check("alarm0_untouched", al_t(), 'h0000);
        check("time_hhmm_untouched", now_t() >> 8, 'h0000);
        alarm_en = 4'b0110;

        // alarm 1 wins over alarm 2
        goto_0729();
        run_to_alarm("ring1");
        check("ring1_on", 32'(ring), 1);
        check("ring1_id", 32'(ring_id), 1);

        // snooze twice, then stop together with snooze
        snooze = 1'b1; step(1); snooze = 1'b0;
        check("snooze_off", 32'(ring), 0);
        adv(299);
        check("snooze_time", now_t(), 'h073459);
        check("snooze_still_off", 32'(ring), 0);
        adv(1);
        check("snooze_rering", 32'(ring), 1);
        snooze = 1'b1; step(1); snooze = 1'b0;
        adv(300);
        check("snooze2_time", now_t(), 'h074000);
        check("snooze2_rering", 32'(ring), 1);
        stop = 1'b1; snooze = 1'b1; step(1); stop = 1'b0; snooze = 1'b0;
        check("stop_wins", 32'(ring), 0);
        adv(360);
        check("stays_quiet", 32'(ring), 0);

        // auto-stop after one minute
        goto_0729();
        run_to_alarm("ring2");
        check("ring2_on", 32'(ring), 1);
        adv(59);
        check("autostop_before", 32'(ring), 1);
        adv(1);
        check("autostop_time", now_t(), 'h073100);
        check("autostop_off", 32'(ring), 0);

        // editing the ringing alarm keeps ringing; disarming stops it
        goto_0729();
        run_to_alarm("ring3");
        check("ring3_on", 32'(ring), 1);
        sel_alarm = 1'b1;
        alarm_idx = 2'd1;
        press_adj();
        press_add();
        check("alarm1_edit", al_t(), 'h0830);
        check("edit_keeps_ring", 32'(ring), 1);
        press_adj();
        press_adj();
        alarm_en = 4'b0100;
        check("disarm_same_cycle", 32'(ring), 1);
        step(1);
        check("disarm_next_cycle", 32'(ring), 0);

        // async reset while ringing alarm 2 in hour edit
        alarm_en = 4'b0110;
        goto_0729();
        run_to_alarm("ring4");
        check("ring4_id", 32'(ring_id), 2);
        sel_alarm = 1'b0;
        press_adj();
        check("ring4_edit_adj", 32'(adjust), 1);
        check("ring4_edit_ring", 32'(ring), 1);
        rst = 1'b1;
        #1;
        check("arst_time", now_t(), 'h000000);
        check("arst_adjust", 32'(adjust), 0);
        check("arst_ring", 32'(ring), 0);
        check("arst_ring_id", 32'(ring_id), 0);
        check("arst_sec_tick", 32'(sec_tick), 0);
        check("arst_alarm2", al_t(), 'h0000);
        glitch = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (sec_tick) glitch++;
        end
        check("arst_no_tick", 32'(glitch), 0);
        rst = 1'b0;
        c = 0;
        while (sec_tick !== 1'b1 && c < 20) begin step(1); c++; end
        check("post_rst_first_tick", 32'(c), 9);
        step(1);
        check("post_rst_time", now_t(), 'h000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_alarm_ctrl.md
MULTI_ALARM_CTRL -- requirements
Module: multi_alarm_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, input clock cycles per second.
REQ-002 The block SHALL have parameter N_ALARM, default 4, number of independent alarms, range 1..8.
REQ-003 The block SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes, range 1..59.
REQ-004 The block SHALL have parameter RING_MIN, default 1, auto-stop ring length in minutes, range 1..59.
REQ-005 The block SHALL have port clk, input, 1, system clock; one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port sel_alarm, input, 1, level: 0 edits time, 1 edits alarm alarm_idx.
REQ-008 The block SHALL have port alarm_idx, input, clog2(N_ALARM) (min 1), alarm under edit.
REQ-009 The block SHALL have port alarm_en, input, N_ALARM, per-alarm arm bit.
REQ-010 The block SHALL have ports key_adj, key_add, key_sub, snooze, stop; input, 1 each; one-cycle debounced pulses.
REQ-011 The block SHALL have ports hour_h, hour_l, min_h, min_l, sec_h, sec_l; output, 4 each; BCD current time.
REQ-012 The block SHALL have ports al_hour_h, al_hour_l, al_min_h, al_min_l; output, 4 each; BCD of alarm alarm_idx.
REQ-013 The block SHALL have port adjust, output, 2, edit state: 0 run, 1 hour, 2 minute.
REQ-014 The block SHALL have ports ring, output, 1; ring_id, output, clog2(N_ALARM); sec_tick, output, 1.

Function
REQ-015 Prescaler SHALL count 0..CLK_FREQ-1 and pulse sec_tick for one cycle at CLK_FREQ-1.
REQ-016 Time SHALL advance on sec_tick as BCD 00:00:00..23:59:59, wrapping to 00:00:00; never a non-BCD digit.
REQ-017 Edit FSM SHALL cycle RUN->HOUR->MIN->RUN on key_adj; adjust reflects state the cycle after the pulse.
REQ-018 In HOUR/MIN, key_add/key_sub SHALL modify the hour (mod 24) or minute (mod 60) of the target chosen by sel_alarm, wrapping 23->00, 00->23, 59->00, 00->59.
REQ-019 key_add and key_sub in the same cycle SHALL be ignored; edit keys in RUN SHALL be ignored.
REQ-020 Editing time minute SHALL clear seconds to 00 and reset the prescaler; editing hour SHALL not touch seconds.
REQ-021 While editing time (sel_alarm=0, adjust!=0) seconds SHALL still count but carry into minutes SHALL be suppressed.
REQ-022 Each alarm SHALL store hour/minute in BCD registers; match = alarm_en[i] and hh:mm equal and sec = 00, evaluated on sec_tick.
REQ-023 Ring FSM SHALL have states QUIET, RINGING, SNOOZED; ring = 1 only in RINGING.
REQ-024 QUIET->RINGING on match; lowest matching index SHALL win and be latched into ring_id.
REQ-025 RINGING->SNOOZED on snooze; SNOOZED->RINGING after SNOOZE_MIN minute boundaries; snooze count SHALL be unlimited.
REQ-026 RINGING or SNOOZED->QUIET on stop, on clearing alarm_en[ring_id], or after RING_MIN minutes continuous RINGING.
REQ-027 stop and snooze in the same cycle SHALL resolve as stop; new matches while not QUIET SHALL be ignored.
REQ-028 Editing the ringing alarm's hh:mm SHALL not stop the ring.

Reset
REQ-029 On rst, time SHALL be 00:00:00, all alarms 00:00, prescaler 0, adjust 0, Ring FSM QUIET, ring 0, ring_id 0, sec_tick 0.
REQ-030 Reset asserted mid-ring or mid-edit SHALL take effect immediately, asynchronously; release is synchronous to clk.

Verification
REQ-031 CLK_FREQ=10: run 86400 ticks from reset -> time 00:00:00, sec_tick every 10 cycles exactly.
REQ-032 Edit time hour to 23 via key_adj,key_sub; minute key_sub from 00 -> 23:59:00, then 60 ticks -> 00:00:00.
REQ-033 Alarms 1 and 2 both 07:30 enabled, time reaches 07:30:00 -> ring=1, ring_id=1.
REQ-034 Ringing, snooze pulse -> ring=0; after 5 minute boundaries ring=1; stop plus snooze same cycle -> ring=0, QUIET.
REQ-035 Ring left alone with RING_MIN=1 -> ring=0 at 07:31:00; clearing alarm_en[ring_id] mid-ring -> ring=0 next cycle.
REQ-036 rst asserted during RINGING in HOUR edit -> all outputs at reset values same cycle, no sec_tick glitch.
